// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg: shared FSM state type, default geometry and line-alignment helper
package cacheline_adaptor_pkg;

    localparam int s_offset = 5;
    localparam int s_line   = 8 * 2**s_offset;
    localparam int s_beat   = 64;
    localparam int n_beats  = s_line / s_beat;

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } state_t;

    function automatic logic [31:0] line_mask(input int off);
        return ~((32'd1 << off) - 32'd1);
    endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns one line-wide arbiter read/write into an n_beats burst on the
// narrow memory bus and returns a single line-wide completion pulse per burst.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int s_offset = cacheline_adaptor_pkg::s_offset,
    parameter int s_line   = 8 * 2**s_offset,
    parameter int s_beat   = cacheline_adaptor_pkg::s_beat,
    parameter int n_beats  = s_line / s_beat
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              ca_read,
    input  logic              ca_write,
    input  logic [31:0]       ca_addr,
    input  logic [s_line-1:0] ca_wdata,
    output logic [s_line-1:0] ca_rdata,
    output logic              ca_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [s_beat-1:0] pmem_wdata,
    input  logic [s_beat-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int cw = $clog2(n_beats);

    state_t            state, state_n;
    logic [cw-1:0]     cnt;
    logic [31:0]       addr_q;
    logic [s_line-1:0] line_buf, line_next;
    logic              last;

    assign last = cnt == cw'(n_beats - 1);

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n      = state;
        pmem_read    = state == RD_BURST;
        pmem_write   = state == WR_BURST;
        ca_resp      = state == RD_DONE || state == WR_DONE;
        pmem_address = (pmem_read || pmem_write) ? addr_q : '0;
        pmem_wdata   = pmem_write ? line_buf[s_beat*int'(cnt) +: s_beat] : '0;
        case (state)
            IDLE:     state_n = ca_write ? WR_BURST : ca_read ? RD_BURST : IDLE;
            RD_BURST: state_n = (pmem_resp && last) ? RD_DONE : RD_BURST;
            WR_BURST: state_n = (pmem_resp && last) ? WR_DONE : WR_BURST;
            default:  state_n = IDLE;
        endcase
    end

    // line_next carries the freshly arrived beat so the final beat can reach ca_rdata
    // on the same edge that enters RD_DONE.
    always_comb begin
        line_next = line_buf;
        line_next[s_beat*int'(cnt) +: s_beat] = pmem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            addr_q   <= '0;
            line_buf <= '0;
            ca_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ca_write || ca_read) begin
                        addr_q <= ca_addr & line_mask(s_offset);
                        cnt    <= '0;
                    end
                    if (ca_write)
                        line_buf <= ca_wdata;
                end
                RD_BURST: begin
                    if (pmem_resp) begin
                        line_buf <= line_next;
                        cnt      <= cnt + cw'(1);
                        if (last)
                            ca_rdata <= line_next;
                    end
                end
                WR_BURST: begin
                    if (pmem_resp)
                        cnt <= cnt + cw'(1);
                end
                default: ;
            endcase
        end
    end

    a_excl_strobe: assert property (@(posedge clk) !(pmem_read && pmem_write));
    a_resp_pulse:  assert property (@(posedge clk) disable iff (!rst) ca_resp |=> !ca_resp);

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: vector table plus scoreboard of expected ca_rdata per burst,
// with hand-written reset-mid-burst and idle-spurious-response sequences.
module tb_cacheline_adaptor;

    logic         clk = 0;
    logic         rst = 0;
    logic         ca_read = 0, ca_write = 0;
    logic [31:0]  ca_addr = 0;
    logic [255:0] ca_wdata = 0;
    logic [255:0] ca_rdata;
    logic         ca_resp;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata = 0;
    logic         pmem_resp = 0;

    always #5 clk = ~clk;

    cacheline_adaptor dut (
        .clk(clk), .rst(rst),
        .ca_read(ca_read), .ca_write(ca_write), .ca_addr(ca_addr),
        .ca_wdata(ca_wdata), .ca_rdata(ca_rdata), .ca_resp(ca_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
        int           mode;
        logic         mangle;
        logic [31:0]  exp_addr;
        logic         exp_wr;
        int           exp_cyc;
    } vec_t;

    vec_t         vecs[5];
    logic [255:0] exp_q[$];
    logic [255:0] model_rdata = '0;
    int           checks = 0;
    int           failures = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic bit resp_pat(input int mode, input int cyc);
        return mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : (cyc >= 3);
    endfunction

    task automatic chk_all_zero(input string name);
        chk({name, "_ca_resp"}, ca_resp, 0);
        chk({name, "_strobes"}, {pmem_read, pmem_write}, 0);
        chk({name, "_pmem_address"}, pmem_address, 0);
        chk({name, "_pmem_wdata"}, pmem_wdata, 0);
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT in IDLE.
    task automatic run_vec(input vec_t v);
        int k = 0;
        int resp_cyc = 0;
        ca_read  = v.rd;
        ca_write = v.wr;
        ca_addr  = v.addr;
        ca_wdata = v.wr ? v.data : ~v.data;
        pmem_resp = 0;
        if (v.wr)
            exp_q.push_back(model_rdata);
        else begin
            model_rdata = v.data;
            exp_q.push_back(v.data);
        end
        for (int cyc = 1; cyc <= 40 && resp_cyc == 0; cyc++) begin
            @(negedge clk);
            pmem_resp = 0;
            if (ca_resp) begin
                resp_cyc = cyc;
                if (exp_q.size() == 0)
                    chk("resp_unexpected", 1, 0);
                else
                    chk("ca_rdata", ca_rdata, exp_q.pop_front());
                chk("beats_before_resp", k, 4);
                chk("strobes_in_done", {pmem_read, pmem_write}, 0);
                if (v.exp_cyc != 0)
                    chk("resp_cycle", cyc, v.exp_cyc);
                ca_read  = 0;
                ca_write = 0;
            end else if (pmem_read || pmem_write) begin
                chk("strobe_dir", {pmem_read, pmem_write}, v.exp_wr ? 2'b01 : 2'b10);
                chk("pmem_address", pmem_address, v.exp_addr);
                if (resp_pat(v.mode, cyc)) begin
                    pmem_resp = 1;
                    if (pmem_write)
                        chk("pmem_wdata", pmem_wdata, v.data[64*k +: 64]);
                    else
                        pmem_rdata = v.data[64*k +: 64];
                    k++;
                    if (v.mangle && k == 1) begin
                        ca_read  = 0;
                        ca_write = 0;
                        ca_addr  = 32'hDEAD_BEEF;
                        ca_wdata = '1;
                    end
                end
            end
        end
        if (resp_cyc == 0)
            chk("resp_timeout", 0, 1);
        @(negedge clk);
        pmem_resp = 0;
        chk("resp_one_cycle", ca_resp, 0);
        chk("idle_strobes", {pmem_read, pmem_write}, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_1234,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    2, 1'b0, 32'h0000_1220, 1'b0, 7};
        vecs[1] = '{1'b0, 1'b1, 32'h8000_00E0,
                    {64'hD3D3_0303_D3D3_0303, 64'hD2D2_0202_D2D2_0202,
                     64'hD1D1_0101_D1D1_0101, 64'hD0D0_0000_D0D0_0000},
                    1, 1'b0, 32'h8000_00E0, 1'b1, 9};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0F3F,
                    {64'hCAFE_0003_CAFE_0003, 64'hCAFE_0002_CAFE_0002,
                     64'hCAFE_0001_CAFE_0001, 64'hCAFE_0000_CAFE_0000},
                    0, 1'b0, 32'h0000_0F20, 1'b1, 5};
        vecs[3] = '{1'b1, 1'b0, 32'hABCD_EF77,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h5A5A_A5A5_5A5A_A5A5, 64'h0F0F_F0F0_0F0F_F0F0},
                    0, 1'b1, 32'hABCD_EF60, 1'b0, 5};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF,
                    {64'h9999_8888_7777_6666, 64'h5555_4444_3333_2222,
                     64'h1111_0000_FFFF_EEEE, 64'hDDDD_CCCC_BBBB_AAAA},
                    1, 1'b0, 32'hFFFF_FFE0, 1'b0, 9};

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_ca_rdata", ca_rdata, 0);
        rst = 1;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            run_vec(vecs[i]);

        // reset lands on the edge that would accept the second read beat
        ca_read = 1;
        ca_addr = 32'h0000_0040;
        @(negedge clk);
        pmem_resp  = 1;
        pmem_rdata = 64'h7777_7777_7777_7777;
        @(negedge clk);
        pmem_rdata = 64'h8888_8888_8888_8888;
        rst     = 0;
        ca_read = 0;
        @(negedge clk);
        pmem_resp = 0;
        chk_all_zero("mid_reset");
        chk("mid_reset_ca_rdata", ca_rdata, 0);
        rst = 1;
        model_rdata = '0;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_idle", {ca_resp, pmem_read, pmem_write}, 0);
        end
        run_vec(vecs[4]);

        pmem_resp = 1;
        repeat (3) begin
            @(negedge clk);
            chk("spurious_resp_idle", {ca_resp, pmem_read, pmem_write}, 0);
        end
        pmem_resp = 0;
        @(negedge clk);
        run_vec(vecs[0]);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits directly downstream of the cache arbiter, between its single line-wide port and physical memory.
- Converts one line-wide read or write into a fixed-length burst of narrow beats on the memory bus.
- Returns exactly one line-wide response to the arbiter per burst.
- Hides burst sequencing, beat packing/unpacking and address alignment from the arbiter and caches.

Parameters:
- s_offset, default 5: log2 of line size in bytes.
- s_line, default 256: line width in bits, equal to 8*2**s_offset.
- s_beat, default 64: memory data bus width in bits.
- n_beats, default s_line/s_beat (4): beats per burst; must be a power of two and at least 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- ca_read  in  1  line read request from arbiter; held until ca_resp.
- ca_write  in  1  line write request from arbiter; held until ca_resp.
- ca_addr  in  32  line address.
- ca_wdata  in  s_line  line write data.
- ca_rdata  out  s_line  assembled read line.
- ca_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  burst read strobe.
- pmem_write  out  1  burst write strobe.
- pmem_address  out  32  line-aligned burst address.
- pmem_wdata  out  s_beat  current write beat.
- pmem_rdata  in  s_beat  current read beat.
- pmem_resp  in  1  beat accepted/valid; one beat per cycle where high.

Behaviour:
- Reset (rst==0 at a rising edge):
  - state goes to IDLE; beat counter goes to 0.
  - Line buffer, ca_rdata and latched address go to 0.
  - ca_resp, pmem_read and pmem_write are 0.
  - pmem_address and pmem_wdata are 0.
  - Reset mid-burst abandons the burst immediately; no ca_resp is issued.
- States: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
- IDLE:
  - ca_write=1 latches {ca_addr[31:s_offset], zeros}, loads ca_wdata into the line buffer, counter=0, then goes to WR_BURST.
  - Otherwise ca_read=1 latches the address, counter=0, then goes to RD_BURST.
  - Write wins if both are asserted.
  - pmem_resp in IDLE is ignored.
- RD_BURST:
  - pmem_read=1 and pmem_address=latched address for every cycle of the state.
  - On each pmem_resp cycle, pmem_rdata is written to line buffer bits [s_beat*cnt +: s_beat] and cnt increments.
  - The beat with cnt==n_beats-1 goes to RD_DONE.
  - Gaps in pmem_resp simply stall the burst.
- RD_DONE:
  - ca_resp=1 for exactly one cycle; pmem_read=0.
  - ca_rdata = assembled line; next state IDLE.
- WR_BURST:
  - pmem_write=1, pmem_address=latched address.
  - pmem_wdata = line buffer [s_beat*cnt +: s_beat], driven combinationally from cnt.
  - On pmem_resp, cnt increments; the last beat goes to WR_DONE.
- WR_DONE: ca_resp=1 for one cycle; next state IDLE.
- ca_rdata is a registered output:
  - Updated only when a read burst completes.
  - Holds its value otherwise, including across writes.
- Once latched, a request cannot be aborted. Deassertion of ca_read/ca_write or changes to ca_addr/ca_wdata mid-burst are ignored.
- Counter is log2(n_beats) bits and wraps to 0 on the last beat.
- Latency: request sampled in IDLE at edge 0 gives a strobe from cycle 1. With pmem_resp high every cycle from cycle 1, beats land in cycles 1..4 and ca_resp is high in cycle 5.
- Back-to-back requests: after the ca_resp cycle the block is in IDLE, and a new request is accepted the following edge. There is no IDLE bypass.
- pmem_read and pmem_write are never both 1.

Decomposition:
- Shared package cacheline_adaptor_pkg holds:
  - state enum type;
  - constants s_line, s_beat, n_beats;
  - the line-alignment mask.
- Flat module; no sub-module warranted.

Test Plan:
- Read, addr 0x0000_1234, pmem_resp high cycles 3-6, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44:
  - pmem_address = 0x0000_1220.
  - ca_resp for exactly one cycle in cycle 7.
  - ca_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write, addr 0x8000_00E0, ca_wdata = {D3, D2, D1, D0}, pmem_resp high with one-cycle gaps:
  - pmem_wdata shows D0, D1, D2, D3 in order, each held until its resp.
  - pmem_write drops after the 4th beat.
  - One ca_resp, and ca_rdata is unchanged.
- ca_read and ca_write asserted together:
  - Only pmem_write bursts.
  - ca_resp once, after 4 beats.
- rst low during the 2nd read beat:
  - Next cycle all outputs are 0 and state is IDLE.
  - A fresh read then completes normally, with ca_rdata holding only the new data.
- ca_read dropped and ca_addr changed mid-burst:
  - pmem_address stays at the original aligned value.
  - All 4 beats complete and ca_resp pulses.
- Spurious pmem_resp while IDLE: no state change and ca_resp stays 0.
